instr_fetch: RTL

Instruction fetch stage for the single-issue RV32I core. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned instruction word into a 2-entry fetch buffer. It presents {pc, instr} pairs to decode over a valid/ready handshake, with branch/jump redirect and fetch-enable control.

---
 rtl/core_pkg.sv | 19 +
 rtl/fetch_buf.sv | 78 +++++++
 rtl/instr_fetch.sv | 66 ++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the RV32I pipeline.
// Provides XLEN, PC step, NOP encoding and the fetch-entry bundle.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch FIFO holding {pc, instr} pairs for decode.
// Ports: clk, rst (async high); push/pop/flush controls; push_pc/push_instr in;
//        head_pc/head_instr out (head entry registers); count (0..2).
module fetch_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic [1:0]      count
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    fetch_entry_t in_entry;

    assign in_entry = '{pc: push_pc, instr: push_instr};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = in_entry;
                    end else begin
                        tail_d = in_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Full: shift tail up, new word behind it.
                    // Single entry: the new word replaces the head.
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = in_entry;
                    end else begin
                        head_d = in_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_pc    = head_q.pc;
    assign head_instr = head_q.instr;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational imem,
// buffers words in fetch_buf and hands {pc, instr} to decode (valid/ready).
// Ports: clk, rst (async high), fetch_en, imem_addr/imem_rdata,
//        redir_valid/redir_pc, if_valid/if_ready/if_instr/if_pc.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    // Redirect wins over everything: the head is not consumed and the
    // word at the old pc is dropped.
    assign pop  = if_valid & if_ready & ~redir_valid;
    assign push = fetch_en & ~redir_valid & ((count != 2'd2) | pop);

    always_comb begin
        pc_d = pc_q;
        if (redir_valid) begin
            pc_d = align_word(redir_pc);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redir_valid),
        .push_pc    (pc_q),
        .push_instr (imem_rdata),
        .head_pc    (if_pc),
        .head_instr (if_instr),
        .count      (count)
    );

    assign imem_addr = pc_q;
    assign if_valid  = (count != 2'd0);

endmodule
